// File: rtl/apb_requester_fsm.sv
// apb_requester_fsm: turns a valid/ready command stream into single-outstanding APB4 transfers
module apb_requester_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pnse,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          expire;

    assign pnse = 1'b0;

    // This ACCESS cycle is the one that brings the wait count up to the limit
    always_comb begin
        expire = TIMEOUT_CYCLES != 0 && int'(cnt) + 1 >= TIMEOUT_CYCLES;
    end

    // Transfer sequencer with all bus and response outputs registered
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                        pprot     <= cmd_prot;
                        psel      <= 1'b1;
                        cnt       <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        state       <= RESP;
                    end else if (expire) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester_fsm.sv
// tb_apb_requester_fsm: directed and randomized transfers against a cycle-count model of the requester
module tb_apb_requester_fsm;
    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pnse;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    int nchk = 0;
    int nfail = 0;

    apb_requester_fsm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_chk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr);
        chk("paddr", paddr, a);
        chk("pwrite", pwrite, w);
        chk("pwdata", pwdata, wd);
        chk("pstrb", pstrb, w ? st : 4'h0);
        chk("pprot", pprot, pr);
        chk("pnse", pnse, 0);
    endtask

    // One full command: waits = ACCESS cycles with pready low before completion (>= TO means timeout)
    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input logic serr, input logic [31:0] rd, input int hold,
                           input logic keep_valid);
        int n;
        int acc;
        bit to;
        logic [31:0] exp_rd;
        logic exp_err;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        if (cmd_ready !== 1'b1) return;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_prot  = pr;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        to = waits >= TO;
        acc = to ? TO : waits + 1;
        exp_err = to | serr;
        exp_rd = (w | to) ? 32'h0 : rd;
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        bus_chk(a, w, wd, st, pr);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        @(negedge pclk);
        for (int k = 0; k < acc; k++) begin
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_rsp_valid", rsp_valid, 0);
            chk("access_cmd_ready", cmd_ready, 0);
            bus_chk(a, w, wd, st, pr);
            pready  = !to && k == waits;
            pslverr = pready ? serr : 1'($urandom);
            prdata  = pready ? rd : $urandom;
            @(negedge pclk);
        end
        pready = 1'b0;
        chk("resp_psel", psel, 0);
        chk("resp_penable", penable, 0);
        chk("resp_paddr_hold", paddr, a);
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_timeout", rsp_timeout, to);
            chk("resp_cmd_ready", cmd_ready, 0);
            if (h < hold) begin
                cmd_valid = keep_valid;
                @(negedge pclk);
            end
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_held_cmd_ready", cmd_ready, 0);
        preset = 1'b0;
        // Write, zero wait states
        do_xfer(32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'h0, 0, 1'b0, 32'h0, 0, 1'b0);
        // Read with three wait states
        do_xfer(32'h2004, 1'b0, 32'hA5A5A5A5, 4'hF, 3'h2, 3, 1'b0, 32'h12345678, 0, 1'b0);
        // Write with slave error
        do_xfer(32'h3008, 1'b1, 32'h0BADF00D, 4'h3, 3'h1, 1, 1'b1, 32'h0, 1, 1'b0);
        // Read that never sees pready
        do_xfer(32'h400C, 1'b0, 32'h0, 4'hF, 3'h7, 1000, 1'b0, 32'hFFFFFFFF, 0, 1'b0);
        // Just inside the timeout window
        do_xfer(32'h4010, 1'b0, 32'h0, 4'hF, 3'h0, TO - 1, 1'b0, 32'hCAFEF00D, 0, 1'b0);
        // Long response backpressure with a command waiting, then back-to-back accept
        do_xfer(32'h5000, 1'b0, 32'h0, 4'h0, 3'h4, 2, 1'b1, 32'h55AA55AA, 10, 1'b1);
        do_xfer(32'h5004, 1'b1, 32'h11223344, 4'h5, 3'h4, 0, 1'b0, 32'h0, 0, 1'b0);
        // Reset during ACCESS
        cmd_valid = 1'b1;
        cmd_addr  = 32'h6000;
        cmd_write = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        pready = 1'b0;
        @(negedge pclk);
        chk("pre_rst_penable", penable, 1);
        #2 preset = 1'b1;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_paddr", paddr, 0);
        @(negedge pclk);
        preset = 1'b0;
        do_xfer(32'h7000, 1'b0, 32'h0, 4'hF, 3'h0, 1, 1'b0, 32'h87654321, 0, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            do_xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, 20)), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
